// File: rtl/mem_ext_arbiter.sv
// rtl/mem_ext_arbiter.sv - round-robin line arbiter and 4-beat burst sequencer for the external memory port
module mem_ext_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int PADDR_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             i_req_vld,
    input  logic [NUM_REQ-1:0]             i_req_wr,
    input  logic [NUM_REQ*PADDR_WIDTH-1:0] i_req_paddr,
    input  logic [NUM_REQ*512-1:0]         i_req_wdat,
    input  logic [NUM_REQ*64-1:0]          i_req_mask,
    output logic [NUM_REQ-1:0]             o_req_gnt,
    output logic [NUM_REQ-1:0]             o_req_done,
    output logic [511:0]                   o_req_rdat,
    output logic                           o_mem_ext_rden,
    output logic                           o_mem_ext_wren,
    output logic [15:0]                    o_mem_ext_mask,
    output logic [2:0]                     o_mem_ext_burst,
    output logic [2:0]                     o_mem_ext_burst_size,
    output logic [PADDR_WIDTH-1:0]         o_mem_ext_paddr,
    output logic [127:0]                   o_mem_ext_wdat,
    output logic                           o_mem_ext_burst_start,
    output logic                           o_mem_ext_burst_end,
    output logic                           o_mem_ext_burst_vld,
    input  logic                           i_ext_mmu_rd_ack,
    input  logic                           i_ext_mmu_wr_ack,
    input  logic [127:0]                   i_ext_mmu_rdat,
    input  logic                           i_ext_mmu_rdy
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {IDLE, CMD, RWAIT, WWAIT, RESP} state_t;

    state_t                 state;
    logic [1:0]             beat;
    logic [1:0]             ack_cnt;
    logic [IDW-1:0]         rr_ptr;
    logic [IDW-1:0]         cur_id;
    logic                   cur_wr;
    logic                   wr_seen;
    logic [PADDR_WIDTH-1:0] cur_paddr;
    logic [3:0][127:0]      cur_wdat;
    logic [3:0][15:0]       cur_mask;
    logic [3:0][127:0]      rdat_q;

    logic                   pick_vld;
    logic [IDW-1:0]         pick_id;
    logic                   take;
    logic                   sel_wr;
    logic [PADDR_WIDTH-1:0] sel_paddr;
    logic [3:0][127:0]      sel_wdat;
    logic [3:0][15:0]       sel_mask;
    logic                   in_cmd;
    logic                   rd_hit;

    // Requesters above the pointer win first, then wrap to the lowest index.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!pick_vld && i_req_vld[j] && (IDW'(j) > rr_ptr)) begin
                pick_vld = 1'b1;
                pick_id  = IDW'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!pick_vld && i_req_vld[j] && (IDW'(j) <= rr_ptr)) begin
                pick_vld = 1'b1;
                pick_id  = IDW'(j);
            end
        end
    end

    always_comb begin
        sel_wr    = 1'b0;
        sel_paddr = '0;
        sel_wdat  = '0;
        sel_mask  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pick_id == IDW'(j)) begin
                sel_wr    = i_req_wr[j];
                sel_paddr = i_req_paddr[j*PADDR_WIDTH +: PADDR_WIDTH];
                sel_wdat  = i_req_wdat[j*512 +: 512];
                sel_mask  = i_req_mask[j*64 +: 64];
            end
        end
    end

    assign take   = (state == IDLE) && rst_n && i_ext_mmu_rdy && pick_vld;
    assign in_cmd = (state == CMD);
    assign rd_hit = (state == CMD || state == RWAIT) && !cur_wr && i_ext_mmu_rd_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat      <= 2'd0;
            ack_cnt   <= 2'd0;
            rr_ptr    <= IDW'(NUM_REQ - 1);
            cur_id    <= '0;
            cur_wr    <= 1'b0;
            wr_seen   <= 1'b0;
            cur_paddr <= '0;
            cur_wdat  <= '0;
            cur_mask  <= '0;
            rdat_q    <= '0;
        end else begin
            if (rd_hit) begin
                rdat_q[ack_cnt] <= i_ext_mmu_rdat;
                ack_cnt         <= ack_cnt + 2'd1;
            end
            case (state)
                IDLE: begin
                    if (take) begin
                        rr_ptr    <= pick_id;
                        cur_id    <= pick_id;
                        cur_wr    <= sel_wr;
                        cur_paddr <= sel_paddr;
                        cur_wdat  <= sel_wdat;
                        cur_mask  <= sel_mask;
                        beat      <= 2'd0;
                        ack_cnt   <= 2'd0;
                        wr_seen   <= 1'b0;
                        state     <= CMD;
                    end
                end
                CMD: begin
                    beat <= beat + 2'd1;
                    if (cur_wr && i_ext_mmu_wr_ack) begin
                        wr_seen <= 1'b1;
                    end
                    // A fast controller may finish the read before the command beats end.
                    if (rd_hit && ack_cnt == 2'd3) begin
                        state <= RESP;
                    end else if (beat == 2'd3) begin
                        if (!cur_wr) begin
                            state <= RWAIT;
                        end else if (wr_seen || i_ext_mmu_wr_ack) begin
                            state <= RESP;
                        end else begin
                            state <= WWAIT;
                        end
                    end
                end
                RWAIT: begin
                    if (rd_hit && ack_cnt == 2'd3) begin
                        state <= RESP;
                    end
                end
                WWAIT: begin
                    if (i_ext_mmu_wr_ack) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign o_req_gnt             = take ? (NUM_REQ'(1) << pick_id) : '0;
    assign o_req_done            = (state == RESP) ? (NUM_REQ'(1) << cur_id) : '0;
    assign o_req_rdat            = rdat_q;
    assign o_mem_ext_burst_vld   = in_cmd;
    assign o_mem_ext_burst_start = in_cmd && (beat == 2'd0);
    assign o_mem_ext_burst_end   = in_cmd && (beat == 2'd3);
    assign o_mem_ext_rden        = o_mem_ext_burst_start && !cur_wr;
    assign o_mem_ext_wren        = o_mem_ext_burst_start && cur_wr;
    assign o_mem_ext_burst       = in_cmd ? 3'b011 : 3'b000;
    assign o_mem_ext_burst_size  = in_cmd ? 3'b100 : 3'b000;
    assign o_mem_ext_paddr       = in_cmd ? (cur_paddr & ~PADDR_WIDTH'(63)) : '0;
    assign o_mem_ext_mask        = !in_cmd ? 16'h0000 : (cur_wr ? cur_mask[beat] : 16'hffff);
    assign o_mem_ext_wdat        = (in_cmd && cur_wr) ? cur_wdat[beat] : 128'd0;

endmodule

// File: tb/tb_mem_ext_arbiter.sv
// tb/tb_mem_ext_arbiter.sv - self-checking bench for mem_ext_arbiter
module tb_mem_ext_arbiter;
    localparam int NR = 3;
    localparam int PA = 32;

    localparam logic [127:0] A0 = {4{32'h0000_00a0}};
    localparam logic [127:0] A1 = {4{32'h0000_00a1}};
    localparam logic [127:0] A2 = {4{32'h0000_00a2}};
    localparam logic [127:0] A3 = {4{32'h0000_00a3}};
    localparam logic [127:0] D0 = {4{32'hd000_0000}};
    localparam logic [127:0] D1 = {4{32'hd111_1111}};
    localparam logic [127:0] D2 = {4{32'hd222_2222}};
    localparam logic [127:0] D3 = {4{32'hd333_3333}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NR-1:0]      req_vld = '0;
    logic [NR-1:0]      req_wr = '0;
    logic [NR*PA-1:0]   req_paddr = '0;
    logic [NR*512-1:0]  req_wdat = '0;
    logic [NR*64-1:0]   req_mask = '0;
    logic               rd_ack = 1'b0;
    logic               wr_ack = 1'b0;
    logic [127:0]       rdat = '0;
    logic               rdy = 1'b1;

    logic [NR-1:0]  o_req_gnt, o_req_done;
    logic [511:0]   o_req_rdat;
    logic           o_rden, o_wren, o_start, o_end, o_bvld;
    logic [15:0]    o_mask;
    logic [2:0]     o_burst, o_bsize;
    logic [PA-1:0]  o_paddr;
    logic [127:0]   o_wdat;

    mem_ext_arbiter #(.NUM_REQ(NR), .PADDR_WIDTH(PA)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_vld(req_vld), .i_req_wr(req_wr), .i_req_paddr(req_paddr),
        .i_req_wdat(req_wdat), .i_req_mask(req_mask),
        .o_req_gnt(o_req_gnt), .o_req_done(o_req_done), .o_req_rdat(o_req_rdat),
        .o_mem_ext_rden(o_rden), .o_mem_ext_wren(o_wren), .o_mem_ext_mask(o_mask),
        .o_mem_ext_burst(o_burst), .o_mem_ext_burst_size(o_bsize),
        .o_mem_ext_paddr(o_paddr), .o_mem_ext_wdat(o_wdat),
        .o_mem_ext_burst_start(o_start), .o_mem_ext_burst_end(o_end),
        .o_mem_ext_burst_vld(o_bvld),
        .i_ext_mmu_rd_ack(rd_ack), .i_ext_mmu_wr_ack(wr_ack),
        .i_ext_mmu_rdat(rdat), .i_ext_mmu_rdy(rdy)
    );

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(string name, logic [511:0] act, logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endfunction

    // Transaction-level reference: busy window, grant cycle, ack tally, scheduled done cycle.
    bit           m_busy = 1'b0;
    int           m_rr = NR - 1;
    int           m_id, m_g, m_acks, m_done_cyc, m_pick;
    logic         m_wr;
    logic [PA-1:0] m_addr;
    logic [511:0] m_line, m_rdline, m_rdat = '0;
    logic [63:0]  m_mask;
    int           b;
    logic [NR-1:0] e_gnt, e_done;
    logic [16:0]  e_ctrl;
    logic [15:0]  e_mask;
    logic [127:0] e_wdat;
    logic [PA-1:0] e_paddr;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_rr = NR - 1;
            m_rdat = '0;
            chk("rst_ctrl", 512'({o_req_gnt, o_req_done, o_bvld, o_start, o_end, o_rden, o_wren, o_burst, o_bsize}), 512'd0);
            chk("rst_data", 512'({o_paddr, o_wdat, o_mask}), 512'd0);
            chk("rst_rdat", o_req_rdat, 512'd0);
        end else begin
            e_gnt = '0;
            e_done = '0;
            if (!m_busy && rdy && (req_vld != 0)) begin
                m_pick = -1;
                for (int k = 1; k <= NR; k++)
                    if (m_pick < 0 && req_vld[(m_rr + k) % NR]) m_pick = (m_rr + k) % NR;
                e_gnt = NR'(1) << m_pick;
                m_rr = m_pick;
                m_id = m_pick;
                m_wr = req_wr[m_pick];
                m_addr = req_paddr[m_pick*PA +: PA];
                m_line = req_wdat[m_pick*512 +: 512];
                m_mask = req_mask[m_pick*64 +: 64];
                m_busy = 1'b1;
                m_g = cyc;
                m_acks = 0;
                m_done_cyc = -1;
            end else if (m_busy && cyc >= m_g + 1 && m_done_cyc < 0) begin
                if (!m_wr && rd_ack) begin
                    m_rdline[m_acks*128 +: 128] = rdat;
                    m_acks++;
                    if (m_acks == 4) m_done_cyc = cyc + 1;
                end
                if (m_wr && wr_ack) m_done_cyc = (cyc + 1 > m_g + 5) ? cyc + 1 : m_g + 5;
            end
            e_ctrl = '0;
            e_mask = '0;
            e_wdat = '0;
            e_paddr = '0;
            if (m_busy && cyc >= m_g + 1 && cyc <= m_g + 4) begin
                b = cyc - m_g - 1;
                e_ctrl[10] = 1'b1;
                e_ctrl[9] = (b == 0);
                e_ctrl[8] = (b == 3);
                e_ctrl[7] = (b == 0) && !m_wr;
                e_ctrl[6] = (b == 0) && m_wr;
                e_ctrl[5:0] = 6'b011_100;
                e_mask = m_wr ? m_mask[b*16 +: 16] : 16'hffff;
                e_wdat = m_wr ? m_line[b*128 +: 128] : 128'd0;
                e_paddr = {m_addr[PA-1:6], 6'b0};
            end
            if (m_busy && cyc == m_done_cyc) e_done = NR'(1) << m_id;
            e_ctrl[16:11] = {e_gnt, e_done};
            chk("ctrl", 512'({o_req_gnt, o_req_done, o_bvld, o_start, o_end, o_rden, o_wren, o_burst, o_bsize}), 512'(e_ctrl));
            chk("paddr", 512'(o_paddr), 512'(e_paddr));
            chk("wdat", 512'(o_wdat), 512'(e_wdat));
            chk("mask", 512'(o_mask), 512'(e_mask));
            if (e_done != 0) begin
                if (!m_wr) m_rdat = m_rdline;
                m_busy = 1'b0;
                chk("rdat", o_req_rdat, m_rdat);
            end
        end
    end

    // Memory-side responder: ack offsets counted from the beat-0 cycle.
    bit           auto_en = 1'b0;
    int           rd_first = 4;
    int           wr_off = 3;
    logic [127:0] rd_beats [4];

    initial begin
        forever begin
            @(negedge clk);
            if (auto_en && rst_n && o_start) begin
                if (o_wren) begin
                    repeat (wr_off) @(posedge clk);
                    #1 wr_ack = 1'b1;
                    @(posedge clk);
                    #1 wr_ack = 1'b0;
                end else begin
                    repeat (rd_first) @(posedge clk);
                    #1;
                    for (int k = 0; k < 4; k++) begin
                        rd_ack = 1'b1;
                        rdat = rd_beats[k];
                        @(posedge clk);
                        #1;
                    end
                    rd_ack = 1'b0;
                    rdat = '0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(input string name, output int g);
        g = -1;
        for (int i = 0; i < 60 && g < 0; i++) begin
            @(negedge clk);
            if (o_req_gnt != 0) g = cyc;
        end
        if (g < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no grant within 60 cycles", name);
        end
    endtask

    task automatic wait_done(input string name, output int d);
        d = -1;
        for (int i = 0; i < 60 && d < 0; i++) begin
            @(negedge clk);
            if (o_req_done != 0) d = cyc;
        end
        if (d < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no done within 60 cycles", name);
        end
    endtask

    task automatic set_req(input int i, input logic wr, input logic [PA-1:0] a,
                           input logic [511:0] line, input logic [63:0] m);
        req_wr[i] = wr;
        req_paddr[i*PA +: PA] = a;
        req_wdat[i*512 +: 512] = line;
        req_mask[i*64 +: 64] = m;
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = $urandom();
        return l;
    endfunction

    int g, d, g2;
    logic [NR-1:0] order [6];

    initial begin
        for (int k = 0; k < 4; k++) rd_beats[k] = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Single write from req0, ack well after the burst
        set_req(0, 1'b1, 32'h1000_0047, {A3, A2, A1, A0}, {64{1'b1}});
        wr_off = 6;
        auto_en = 1'b1;
        req_vld = 3'b001;
        wait_gnt("w0_gnt", g);
        chk("w0_gnt_id", 512'(o_req_gnt), 512'(3'b001));
        step();
        req_vld = 3'b000;
        while (cyc < g + 2) step();
        @(negedge clk);
        chk("w0_beat1_wdat", 512'(o_wdat), 512'(A1));
        chk("w0_paddr", 512'(o_paddr), 512'(32'h1000_0040));
        wait_done("w0_done", d);
        chk("w0_done_lat", 512'(d - g), 512'(8));
        chk("w0_done_id", 512'(o_req_done), 512'(3'b001));

        // Read from req1, beats after the command
        set_req(1, 1'b0, 32'h2000_0080, rand_line(), 64'h0);
        rd_beats[0] = D0; rd_beats[1] = D1; rd_beats[2] = D2; rd_beats[3] = D3;
        rd_first = 4;
        step();
        req_vld = 3'b010;
        wait_gnt("r1_gnt", g);
        step();
        req_vld = 3'b000;
        wait_done("r1_done", d);
        chk("r1_done_lat", 512'(d - g), 512'(9));
        chk("r1_rdat", o_req_rdat, {D3, D2, D1, D0});

        // Read from req2 with acks overlapping command beats 2 and 3
        set_req(2, 1'b0, 32'h3000_00c0, rand_line(), 64'h0);
        rd_beats[0] = D3; rd_beats[1] = D2; rd_beats[2] = D1; rd_beats[3] = D0;
        rd_first = 2;
        step();
        req_vld = 3'b100;
        wait_gnt("r2_gnt", g);
        step();
        req_vld = 3'b000;
        wait_done("r2_done", d);
        chk("r2_done_lat", 512'(d - g), 512'(7));
        chk("r2_rdat", o_req_rdat, {D0, D1, D2, D3});

        // Controller not ready: request must wait
        set_req(0, 1'b1, 32'h4000_0000, rand_line(), {$urandom(), $urandom()});
        wr_off = 3;
        step();
        rdy = 1'b0;
        req_vld = 3'b001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rdy0_gnt", 512'(o_req_gnt), 512'd0);
            chk("rdy0_bvld", 512'(o_bvld), 512'd0);
        end
        step();
        rdy = 1'b1;
        @(negedge clk);
        chk("rdy1_gnt", 512'(o_req_gnt), 512'(3'b001));
        step();
        req_vld = 3'b000;
        wait_done("rdy1_done", d);

        // Fresh reset, all three requesting continuously
        step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        set_req(0, 1'b1, 32'h5000_0011, rand_line(), {$urandom(), $urandom()});
        set_req(1, 1'b0, 32'h6000_0022, rand_line(), {$urandom(), $urandom()});
        set_req(2, 1'b1, 32'h7000_0033, rand_line(), {$urandom(), $urandom()});
        for (int k = 0; k < 4; k++) rd_beats[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
        rd_first = 4;
        req_vld = 3'b111;
        for (int i = 0; i < 6; i++) begin
            wait_gnt("rr_gnt", g);
            order[i] = o_req_gnt;
        end
        step();
        req_vld = 3'b010;
        chk("rr_order0", 512'(order[0]), 512'(3'b001));
        chk("rr_order1", 512'(order[1]), 512'(3'b010));
        chk("rr_order2", 512'(order[2]), 512'(3'b100));
        chk("rr_order3", 512'(order[3]), 512'(3'b001));
        chk("rr_order4", 512'(order[4]), 512'(3'b010));
        chk("rr_order5", 512'(order[5]), 512'(3'b100));
        wait_gnt("solo_gnt_a", g);
        chk("solo_id_a", 512'(o_req_gnt), 512'(3'b010));
        wait_done("solo_done_a", d);
        wait_gnt("solo_gnt_b", g2);
        chk("solo_id_b", 512'(o_req_gnt), 512'(3'b010));
        chk("solo_b2b", 512'(g2 - d), 512'(1));
        step();
        req_vld = 3'b000;
        wait_done("solo_done_b", d);

        // Reset during beat 2 of a write, then req2 alone
        auto_en = 1'b0;
        set_req(0, 1'b1, 32'h8000_0040, rand_line(), {64{1'b1}});
        step();
        req_vld = 3'b001;
        wait_gnt("ab_gnt", g);
        step();
        req_vld = 3'b000;
        while (cyc < g + 3) step();
        rst_n = 1'b0;
        #1;
        chk("ab_bvld", 512'(o_bvld), 512'd0);
        chk("ab_wdat", 512'(o_wdat), 512'd0);
        step();
        step();
        rst_n = 1'b1;
        auto_en = 1'b1;
        set_req(2, 1'b1, 32'h9000_0000, rand_line(), {$urandom(), $urandom()});
        req_vld = 3'b100;
        wait_gnt("ab_req2_gnt", g);
        chk("ab_req2_id", 512'(o_req_gnt), 512'(3'b100));
        step();
        req_vld = 3'b000;
        wait_done("ab_req2_done", d);
        chk("ab_req2_done_id", 512'(o_req_done), 512'(3'b100));

        repeat (4) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
